// File: rtl/mux_arb_pkg.sv
// Shared definitions for the mux_arb_n channel multiplexer/arbiter.
package mux_arb_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

endpackage

// File: rtl/mux_arb_n_rr_arbiter.sv
// Round-robin grant: first requesting channel at or after ptr, wrapping.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [SEL_W-1:0]  idx
);

    // Scan NUM_CH positions starting at ptr; the first hit wins.
    always_comb begin
        int  c;
        logic found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        c     = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            c = int'(ptr) + k;
            if (c >= NUM_CH) begin
                c = c - NUM_CH;
            end
            if (!found && req[c]) begin
                found    = 1'b1;
                grant[c] = 1'b1;
                idx      = SEL_W'(c);
            end
        end
    end

endmodule

// File: rtl/mux_arb_n.sv
// N-channel valid/ready multiplexer with a one-deep registered output.
// Fixed-select or round-robin arbitration.
// Optional packet lock: define MUX_ARB_N_LOCK_EN to add in_last/out_last
// and hold the grant on one channel until its last beat.
//
//   state  | meaning
//   IDLE   | per-beat arbitration (fixed select or round-robin)
//   LOCKED | grant pinned to lock_ch_q until a beat with in_last=1 transfers
module mux_arb_n
    import mux_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mode,
    input  logic [SEL_W-1:0]           sel,
    input  logic [NUM_CH-1:0]          in_valid,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    output logic [NUM_CH-1:0]          in_ready,
    input  logic                       out_ready,
`ifdef MUX_ARB_N_LOCK_EN
    input  logic [NUM_CH-1:0]          in_last,
    output logic                       out_last,
`endif
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_data,
    output logic [SEL_W-1:0]           out_ch
);

    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q,  out_data_d;
    logic [SEL_W-1:0]    out_ch_q,    out_ch_d;
    logic [SEL_W-1:0]    rr_ptr_q,    rr_ptr_d;

    logic                free;
    logic                xfer;
    logic                lock_active;
    logic                pkt_end;
    logic [NUM_CH-1:0]   locked_vec;
    logic [SEL_W-1:0]    locked_idx;
    logic [NUM_CH-1:0]   rr_grant;
    logic [SEL_W-1:0]    rr_idx;
    logic [NUM_CH-1:0]   grant_vec;
    logic [SEL_W-1:0]    grant_idx;
    logic [DATA_W-1:0]   mux_data;
    logic [SEL_W-1:0]    ptr_next;

    assign free = !out_valid_q || out_ready;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_rr (
        .req   (in_valid),
        .ptr   (rr_ptr_q),
        .grant (rr_grant),
        .idx   (rr_idx)
    );

    // Grant selection: a held lock overrides mode; out-of-range sel grants nothing.
    always_comb begin
        grant_vec = '0;
        grant_idx = '0;
        if (lock_active) begin
            grant_vec = locked_vec;
            grant_idx = locked_idx;
        end else if (mode == MODE_RR) begin
            grant_vec = rr_grant;
            grant_idx = rr_idx;
        end else if (int'(sel) < NUM_CH) begin
            grant_vec = NUM_CH'(1) << sel;
            grant_idx = sel;
        end
    end

    assign in_ready = (rst || !free) ? '0 : grant_vec;
    assign xfer     = |(in_valid & in_ready);

    // Data mux driven by the one-hot grant so no index can run past NUM_CH.
    always_comb begin
        mux_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_vec[i]) begin
                mux_data = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign ptr_next = (int'(grant_idx) == NUM_CH - 1) ? '0 : grant_idx + SEL_W'(1);

    // Output register and round-robin pointer next-state.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (free) begin
            out_valid_d = xfer;
            if (xfer) begin
                out_data_d = mux_data;
                out_ch_d   = grant_idx;
            end
        end
        if (xfer && mode == MODE_RR && pkt_end) begin
            rr_ptr_d = ptr_next;
        end
    end

    // State update; reset drops any held beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

`ifdef MUX_ARB_N_LOCK_EN
    lock_state_t       lock_q,     lock_d;
    logic [SEL_W-1:0]  lock_ch_q,  lock_ch_d;
    logic              out_last_q, out_last_d;
    logic              last_bit;

    assign last_bit    = |(in_last & grant_vec);
    assign lock_active = (lock_q == LOCKED);
    assign pkt_end     = last_bit;
    assign locked_vec  = NUM_CH'(1) << lock_ch_q;
    assign locked_idx  = lock_ch_q;

    // Lock FSM: a non-last beat opens a packet, a last beat closes it.
    always_comb begin
        lock_d     = lock_q;
        lock_ch_d  = lock_ch_q;
        out_last_d = out_last_q;
        if (free) begin
            out_last_d = xfer && last_bit;
        end
        if (xfer) begin
            if (lock_q == IDLE && !last_bit) begin
                lock_d    = LOCKED;
                lock_ch_d = grant_idx;
            end else if (lock_q == LOCKED && last_bit) begin
                lock_d = IDLE;
            end
        end
    end

    // Lock state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q     <= IDLE;
            lock_ch_q  <= '0;
            out_last_q <= 1'b0;
        end else begin
            lock_q     <= lock_d;
            lock_ch_q  <= lock_ch_d;
            out_last_q <= out_last_d;
        end
    end

    assign out_last = out_last_q;
`else
    assign lock_active = 1'b0;
    assign pkt_end     = 1'b1;
    assign locked_vec  = '0;
    assign locked_idx  = '0;
`endif

endmodule

// File: tb/tb_mux_arb_n.sv
// Directed bench for mux_arb_n: fixed select, round-robin order and wrap,
// backpressure hold, drain, reset and out-of-range select; packet lock
// when MUX_ARB_N_LOCK_EN is defined.
module tb_mux_arb_n;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;   // wide enough to drive sel=5

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [NUM_CH-1:0]         in_valid;
    logic [NUM_CH*DATA_W-1:0]  in_data;
    logic [NUM_CH-1:0]         in_ready;
    logic                      out_ready;
    logic                      out_valid;
    logic [DATA_W-1:0]         out_data;
    logic [SEL_W-1:0]          out_ch;
`ifdef MUX_ARB_N_LOCK_EN
    logic [NUM_CH-1:0]         in_last;
    logic                      out_last;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mux_arb_n #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_ready (out_ready),
`ifdef MUX_ARB_N_LOCK_EN
        .in_last   (in_last),
        .out_last  (out_last),
`endif
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Expect a registered beat after the next edge.
    task automatic beat(input string tag, input logic [2:0] ch, input logic [7:0] data);
        step();
        chk({tag, ".valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".ch"},    32'(out_ch),    32'(ch));
        chk({tag, ".data"},  32'(out_data),  32'(data));
    endtask

    initial begin
        rst       = 1'b1;
        mode      = 1'b0;
        sel       = 3'd0;
        in_valid  = 4'b1111;
        in_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        out_ready = 1'b1;
`ifdef MUX_ARB_N_LOCK_EN
        in_last   = 4'b1111;
`endif
        settle();
        chk("rst.in_ready", 32'(in_ready), 32'd0);
        step();
        step();
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.out_data",  32'(out_data),  32'd0);
        chk("rst.out_ch",    32'(out_ch),    32'd0);

        // Fixed select on channel 2.
        rst  = 1'b0;
        sel  = 3'd2;
        settle();
        chk("fix.in_ready", 32'(in_ready), 32'b0100);
        for (int i = 0; i < 3; i++) begin
            beat("fix", 3'd2, 8'h12);
            chk("fix.in_ready_hold", 32'(in_ready), 32'b0100);
        end

        // Round-robin across all four channels, no bubbles.
        mode = 1'b1;
        settle();
        chk("rr.in_ready0", 32'(in_ready), 32'b0001);
        beat("rr0", 3'd0, 8'h10);
        beat("rr1", 3'd1, 8'h11);
        beat("rr2", 3'd2, 8'h12);
        beat("rr3", 3'd3, 8'h13);
        beat("rr4", 3'd0, 8'h10);

        // Pointer now 1: one grant to ch1 moves it to 2, then 3 then wrap to 1.
        in_valid = 4'b0010;
        beat("wrap_a", 3'd1, 8'h11);
        in_valid = 4'b1010;
        settle();
        chk("wrap.in_ready3", 32'(in_ready), 32'b1000);
        beat("wrap_b", 3'd3, 8'h13);
        chk("wrap.in_ready1", 32'(in_ready), 32'b0010);
        beat("wrap_c", 3'd1, 8'h11);

        // Backpressure: beat A5 held for three cycles.
        mode     = 1'b0;
        sel      = 3'd0;
        in_valid = 4'b1111;
        in_data  = {8'h13, 8'h12, 8'h11, 8'hA5};
        beat("hold_load", 3'd0, 8'hA5);
        out_ready = 1'b0;
        in_data   = {8'h13, 8'h12, 8'h11, 8'h5A};
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("hold.in_ready", 32'(in_ready), 32'd0);
            beat("hold", 3'd0, 8'hA5);
        end
        out_ready = 1'b1;
        settle();
        chk("release.in_ready", 32'(in_ready), 32'b0001);
        beat("release", 3'd0, 8'h5A);

        // Drain with nothing valid.
        mode     = 1'b1;
        in_valid = 4'b0000;
        settle();
        chk("drain.in_ready", 32'(in_ready), 32'd0);
        step();
        chk("drain.out_valid", 32'(out_valid), 32'd0);

        // Reset with a beat held; pointer (currently 2) returns to 0.
        mode     = 1'b0;
        in_valid = 4'b0001;
        beat("pre_rst", 3'd0, 8'h5A);
        out_ready = 1'b0;
        rst       = 1'b1;
        settle();
        chk("rst2.in_ready", 32'(in_ready), 32'd0);
        step();
        chk("rst2.out_valid", 32'(out_valid), 32'd0);
        chk("rst2.out_data",  32'(out_data),  32'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        mode      = 1'b1;
        in_valid  = 4'b1111;
        settle();
        chk("rst2.ptr0", 32'(in_ready), 32'b0001);

        // Out-of-range select grants nothing.
        mode = 1'b0;
        sel  = 3'd5;
        settle();
        chk("sel5.in_ready", 32'(in_ready), 32'd0);
        step();
        chk("sel5.out_valid", 32'(out_valid), 32'd0);

`ifdef MUX_ARB_N_LOCK_EN
        // Three-beat packet on ch0 while ch1 also requests.
        mode     = 1'b1;
        in_valid = 4'b0011;
        in_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        in_last  = 4'b0010;
        beat("lock1", 3'd0, 8'h10);
        chk("lock1.last", 32'(out_last), 32'd0);
        beat("lock2", 3'd0, 8'h10);
        chk("lock2.last", 32'(out_last), 32'd0);
        in_last = 4'b0011;
        beat("lock3", 3'd0, 8'h10);
        chk("lock3.last", 32'(out_last), 32'd1);
        beat("lock4", 3'd1, 8'h11);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
